// File: rtl/cache_controller_if.sv
// Cache controller bus bundle: CPU request side, cache array side and
// main-memory side grouped so the controller takes a single port.
interface cache_controller_if;
  // CPU side
  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic        busy;
  logic        cpu_ready;
  // Cache array side
  logic [14:0] cache_addr;
  logic        read_adr;
  logic        write;
  logic        hit;
  logic        miss;
  logic        valid;
  logic [2:0]  checking_tag;
  // Main memory side
  logic        mem_rd;
  logic [12:0] mem_addr;
  logic        mem_ready;

  modport master (
    input  cpu_req, cpu_addr, valid, checking_tag, mem_ready,
    output busy, cpu_ready, cache_addr, read_adr, write, hit, miss,
           mem_rd, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, valid, checking_tag, mem_ready,
    input  busy, cpu_ready, cache_addr, read_adr, write, hit, miss,
           mem_rd, mem_addr
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped read cache controller: latches a CPU request, strobes the
// cache lookup, compares the registered tag, fetches a block from main
// memory on a miss and keeps saturating hit/miss statistics.
module cache_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_controller_if.master   bus,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    MEM_WAIT,
    FILL,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [14:0]      addr_q, addr_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  // State, latched address, lookup result and statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      hit_q        <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hit_q        <= hit_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Next-state logic; cpu_req only matters in IDLE, mem_ready only in MEM_WAIT
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP:   state_d = COMPARE;
      COMPARE: begin
        hit_d   = bus.valid && (bus.checking_tag == addr_q[14:12]);
        state_d = hit_d ? DONE : MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_ready) state_d = FILL;
      end
      FILL:     state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Saturating statistics, bumped once per completed transaction
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == DONE) begin
      if (hit_q) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
      end
    end
  end

  // Outputs are decoded from state or taken straight from registers
  assign bus.busy       = (state_q != IDLE);
  assign bus.read_adr   = (state_q == LOOKUP);
  assign bus.mem_rd     = (state_q == MEM_WAIT);
  assign bus.write      = (state_q == FILL);
  assign bus.cpu_ready  = (state_q == DONE);
  assign bus.hit        = (state_q == DONE) &&  hit_q;
  assign bus.miss       = (state_q == DONE) && !hit_q;
  assign bus.cache_addr = addr_q;
  assign bus.mem_addr   = addr_q[14:2];
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: behavioural cache array plus
// hand-driven memory handshake; a CNT_W=2 copy shares the stimulus to
// exercise counter saturation.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hit_count, miss_count;
  logic [1:0]  sat_hit, sat_miss;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  cache_controller_if bus ();
  cache_controller_if bus_s ();

  always #5 clk = ~clk;

  cache_controller u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  cache_controller #(.CNT_W(2)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_s),
    .hit_count  (sat_hit),
    .miss_count (sat_miss)
  );

  assign bus_s.cpu_req      = bus.cpu_req;
  assign bus_s.cpu_addr     = bus.cpu_addr;
  assign bus_s.valid        = bus.valid;
  assign bus_s.checking_tag = bus.checking_tag;
  assign bus_s.mem_ready    = bus.mem_ready;

  // Cache array model: registers valid/tag on lookup, fills on write
  bit         v_mem [1024];
  logic [2:0] t_mem [1024];
  always @(posedge clk) begin
    if (bus.read_adr) begin
      bus.valid        <= v_mem[bus.cache_addr[11:2]];
      bus.checking_tag <= t_mem[bus.cache_addr[11:2]];
    end
    if (bus.write) begin
      v_mem[bus.cache_addr[11:2]] <= 1'b1;
      t_mem[bus.cache_addr[11:2]] <= bus.cache_addr[14:12];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from acceptance to the cycle after DONE.
  // delay: MEM_WAIT cycle in which mem_ready is raised; stuck: mem_ready high throughout.
  task automatic txn(input string name, input logic [14:0] addr, input int unsigned delay,
                     input bit exp_hit, input bit stuck, input bit hold_req);
    int unsigned cyc, done_cyc, rd_cyc, wr_cnt, busy_bad, addr_bad, exp_rd;
    bit done, got_hit, got_miss;
    cyc = 1; done_cyc = 0; rd_cyc = 0; wr_cnt = 0; busy_bad = 0; addr_bad = 0;
    done = 0; got_hit = 0; got_miss = 0;
    exp_rd = exp_hit ? 0 : (stuck ? 1 : delay);
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = addr;
    bus.mem_ready = stuck;
    step();
    bus.cpu_req  = hold_req;
    bus.cpu_addr = hold_req ? 15'h7FFF : 15'h0;
    while (!done && cyc <= 40) begin
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.cache_addr !== addr) addr_bad++;
      if (bus.mem_rd === 1'b1) begin
        rd_cyc++;
        if (bus.mem_addr !== addr[14:2]) addr_bad++;
        if (rd_cyc == delay) bus.mem_ready = 1'b1;
      end
      if (bus.write === 1'b1) wr_cnt++;
      if (bus.cpu_ready === 1'b1) begin
        done = 1; done_cyc = cyc; got_hit = bus.hit; got_miss = bus.miss;
      end
      step();
      bus.mem_ready = stuck;
      cyc++;
    end
    bus.mem_ready = 1'b0;
    check({name, "_done"},    32'(done),     32'd1);
    check({name, "_latency"}, done_cyc,      exp_hit ? 32'd3 : 32'(4 + exp_rd));
    check({name, "_hit"},     32'(got_hit),  32'(exp_hit));
    check({name, "_miss"},    32'(got_miss), 32'(!exp_hit));
    check({name, "_mem_rd"},  rd_cyc,        exp_rd);
    check({name, "_write"},   wr_cnt,        exp_hit ? 32'd0 : 32'd1);
    check({name, "_busy"},    busy_bad,      32'd0);
    check({name, "_addr"},    addr_bad,      32'd0);
    check({name, "_idle"},    32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = 15'h0;
    bus.mem_ready = 1'b0;
    repeat (2) step();
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_cache_addr", 32'(bus.cache_addr), 32'd0);
    check("rst_mem_rd",     32'(bus.mem_rd),     32'd0);
    check("rst_cpu_ready",  32'(bus.cpu_ready),  32'd0);
    check("rst_counts",     {hit_count, miss_count}, 32'd0);
    rst_n = 1'b1;
    step();

    // Cold miss: mem_addr 048D, DONE on the 6th cycle after acceptance
    txn("cold_miss", 15'h1234, 2, 1'b0, 1'b0, 1'b0);
    check("cold_miss_cnt", 32'(miss_count), 32'd1);
    check("cold_hit_cnt",  32'(hit_count),  32'd0);

    // Hit after fill; stray mem_ready must be ignored
    txn("hit_fill", 15'h1234, 1, 1'b1, 1'b1, 1'b0);
    check("hit_fill_cnt", 32'(hit_count), 32'd1);

    // Tag conflict, mem_ready already high in first MEM_WAIT cycle
    txn("tag_conf", 15'h5234, 1, 1'b0, 1'b0, 1'b0);
    check("tag_conf_cnt", 32'(miss_count), 32'd2);

    // cpu_req held: one transaction, then IDLE, then next one accepted
    txn("busy_req", 15'h1234, 3, 1'b0, 1'b0, 1'b1);
    txn("busy_req2", 15'h1234, 1, 1'b1, 1'b0, 1'b0);
    check("busy_hit_cnt",  32'(hit_count),  32'd2);
    check("busy_miss_cnt", 32'(miss_count), 32'd3);
    check("sat_miss_hold", 32'(sat_miss),   32'd3);

    // Reset during MEM_WAIT aborts the miss
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 15'h2000;
    step();
    bus.cpu_req = 1'b0;
    step();
    step();
    check("abort_mem_wait", 32'(bus.mem_rd), 32'd1);
    rst_n = 1'b0;
    step();
    check("abort_mem_rd",  32'(bus.mem_rd),     32'd0);
    check("abort_busy",    32'(bus.busy),       32'd0);
    check("abort_addr",    32'(bus.cache_addr), 32'd0);
    check("abort_counts",  {hit_count, miss_count}, 32'd0);
    check("abort_sat",     {sat_hit, sat_miss}, 32'd0);
    step();
    check("abort_strobes", {bus.write, bus.cpu_ready, bus.mem_rd}, 32'd0);
    rst_n = 1'b1;

    // First request after reset accepted on the next edge
    txn("post_rst", 15'h2000, 1, 1'b0, 1'b0, 1'b0);
    check("post_rst_cnt", 32'(miss_count), 32'd1);

    // Five hits: 2-bit counter saturates at 3
    for (int unsigned i = 1; i <= 5; i++) begin
      txn("sat_hit", 15'h2000, 1, 1'b1, 1'b0, 1'b0);
      check("sat_hit_cnt",  32'(sat_hit),   (i < 3) ? 32'(i) : 32'd3);
      check("full_hit_cnt", 32'(hit_count), 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
